mult4_seq: RTL and testbench

Sequential 4x4 unsigned shift-and-add multiplier that drives the team's 4-bit ripple-carry adder (`rip`) as its only arithmetic element. The block sits directly upstream of the adder: each cycle it presents the partial-product high nibble and the multiplicand, then consumes the sum and carry back into its shift registers. A start/busy/done handshake connects it to the surrounding control logic. It produces one 8-bit product every 5 cycles.

---
 rtl/mult_pkg.sv | 18 +
 rtl/mult4_seq_rip.sv | 32 +++
 rtl/mult4_seq.sv | 105 ++++++++++
 tb/tb_mult4_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential 4x4 multiplier.
//   OP_W      : operand width, fixed by the ripple-carry adder
//   PROD_W    : product width
//   ITER_LAST : iteration counter value of the final shift-and-add step
//   st_t      : control FSM states
package mult_pkg;

    localparam int          OP_W      = 4;
    localparam int          PROD_W    = 8;
    localparam logic [1:0]  ITER_LAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } st_t;

endpackage

// File: rtl/mult4_seq_rip.sv
// rip: 4-bit ripple-carry adder, the multiplier's only arithmetic element.
// Ports:
//   s    out 4 : sum a + b + cin (low 4 bits)
//   cout out 1 : carry out of bit 3
//   a    in  4 : addend
//   b    in  4 : addend
//   cin  in  1 : carry in
module rip
    import mult_pkg::*;
(
    output logic [OP_W-1:0] s,
    output logic            cout,
    input  logic [OP_W-1:0] a,
    input  logic [OP_W-1:0] b,
    input  logic            cin
);

    // Carries kept as separate nets so the chain is not one self-feeding vector.
    logic w_c1;
    logic w_c2;
    logic w_c3;

    assign s[0]  = a[0] ^ b[0] ^ cin;
    assign w_c1  = (a[0] & b[0]) | (cin  & (a[0] ^ b[0]));
    assign s[1]  = a[1] ^ b[1] ^ w_c1;
    assign w_c2  = (a[1] & b[1]) | (w_c1 & (a[1] ^ b[1]));
    assign s[2]  = a[2] ^ b[2] ^ w_c2;
    assign w_c3  = (a[2] & b[2]) | (w_c2 & (a[2] ^ b[2]));
    assign s[3]  = a[3] ^ b[3] ^ w_c3;
    assign cout  = (a[3] & b[3]) | (w_c3 & (a[3] ^ b[3]));

endmodule

// File: rtl/mult4_seq.sv
// mult4_seq: sequential 4x4 unsigned shift-and-add multiplier.
// One product every 5 cycles: accept edge, four add/shift iterations,
// then a one-cycle DONE state.
// Ports:
//   clk   in  1 : clock, rising edge
//   rst_n in  1 : synchronous active-low reset
//   start in  1 : request; honoured only in IDLE or DONE
//   a     in  4 : multiplicand, captured on accepted start
//   b     in  4 : multiplier, captured on accepted start
//   busy  out 1 : high while iterating (RUN)
//   done  out 1 : one-cycle completion pulse (DONE)
//   p     out 8 : product, updated only on DONE entry or reset
module mult4_seq
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] p
);

    st_t               r_state;
    logic              r_busy;
    logic              r_done;
    logic [OP_W-1:0]   r_m;
    logic [OP_W-1:0]   r_hi;
    logic [OP_W-1:0]   r_lo;
    logic [1:0]        r_cnt;
    logic [PROD_W-1:0] r_p;

    logic [OP_W-1:0]   w_addend;
    logic [OP_W-1:0]   w_sum;
    logic              w_carry;

    // Add the multiplicand into the high half only when the current
    // multiplier bit (lo[0]) is set.
    assign w_addend = r_lo[0] ? r_m : '0;

    rip u_rip (
        .s    (w_sum),
        .cout (w_carry),
        .a    (r_hi),
        .b    (w_addend),
        .cin  (1'b0)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_m     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
            r_p     <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_m     <= a;
                        r_lo    <= b;
                        r_hi    <= '0;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                RUN: begin
                    // Shift {carry, sum, lo} right by one: the sum's LSB
                    // becomes a finished product bit in lo.
                    r_hi  <= {w_carry, w_sum[OP_W-1:1]};
                    r_lo  <= {w_sum[0], r_lo[OP_W-1:1]};
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == ITER_LAST) begin
                        // Capture the post-shift {hi,lo} directly, since
                        // the registers themselves update on this same edge.
                        r_p     <= {w_carry, w_sum[OP_W-1:1], w_sum[0], r_lo[OP_W-1:1]};
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

endmodule

// File: tb/tb_mult4_seq.sv
// Directed testbench for mult4_seq: reset state, basic and boundary
// products, held start, operand changes while busy, back-to-back requests,
// reset mid-run and an exhaustive sweep of all operand pairs.
module tb_mult4_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] p;

    int checks = 0;
    int errors = 0;

    mult4_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE or DONE and follow it to its DONE cycle.
    // Operands are scrambled while busy; the result must not change.
    task automatic run_op(input logic [3:0] ai, input logic [3:0] bi,
                          input logic [7:0] pexp, input logic [7:0] pold);
        a = ai;
        b = bi;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ai;
        b = ~bi;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_done", 32'(done), 32'd0);
        chk("accept_p", 32'(p), 32'(pold));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_done", 32'(done), 32'd0);
            chk("run_p_hold", 32'(p), 32'(pold));
        end
        tick();
        chk("fin_busy", 32'(busy), 32'd0);
        chk("fin_done", 32'(done), 32'd1);
        chk("fin_p", 32'(p), 32'(pexp));
    endtask

    task automatic idle_chk(input logic [7:0] pexp);
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_p", 32'(p), 32'(pexp));
    endtask

    logic [7:0] prev;

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        a = 4'd7;
        b = 4'd7;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_p", 32'(p), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        idle_chk(8'd0);

        // Basic and boundary products, each followed by an idle cycle
        run_op(4'd13, 4'd11, 8'h8F, 8'h00);
        idle_chk(8'h8F);
        run_op(4'd15, 4'd15, 8'hE1, 8'h8F);
        idle_chk(8'hE1);
        run_op(4'd0, 4'd9, 8'h00, 8'hE1);
        idle_chk(8'h00);
        run_op(4'd9, 4'd1, 8'h09, 8'h00);
        idle_chk(8'h09);

        // Start held for 8 edges: 3*5 first, then 2*7 accepted in DONE
        a = 4'd3;
        b = 4'd5;
        start = 1'b1;
        tick();
        chk("hold_acc_busy", 32'(busy), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 1) begin
                a = 4'd2;
                b = 4'd7;
            end
            chk("hold_run_busy", 32'(busy), 32'd1);
            chk("hold_run_done", 32'(done), 32'd0);
        end
        tick();
        chk("hold_first_done", 32'(done), 32'd1);
        chk("hold_first_p", 32'(p), 32'd15);
        tick();
        chk("hold_reacc_busy", 32'(busy), 32'd1);
        chk("hold_reacc_done", 32'(done), 32'd0);
        chk("hold_reacc_p", 32'(p), 32'd15);
        tick();
        tick();
        start = 1'b0;
        tick();
        chk("hold_second_busy", 32'(busy), 32'd1);
        chk("hold_second_p_hold", 32'(p), 32'd15);
        tick();
        chk("hold_second_done", 32'(done), 32'd1);
        chk("hold_second_p", 32'(p), 32'd14);
        idle_chk(8'd14);

        // Back-to-back: second request lands in the DONE cycle
        run_op(4'd7, 4'd6, 8'd42, 8'd14);
        run_op(4'd12, 4'd12, 8'd144, 8'd42);
        idle_chk(8'd144);

        // Reset during the second RUN cycle
        a = 4'd5;
        b = 4'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_p", 32'(p), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_no_done", 32'(done), 32'd0);
            chk("mid_no_busy", 32'(busy), 32'd0);
        end
        run_op(4'd2, 4'd3, 8'd6, 8'd0);
        idle_chk(8'd6);

        // Exhaustive sweep, issued back-to-back
        prev = 8'd6;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run_op(4'(i), 4'(j), 8'(i * j), prev);
                prev = 8'(i * j);
            end
        end
        idle_chk(prev);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
